ex_mem_stage_reg: RTL and testbench
===================================

// Module: ex_mem_stage_reg
// PURPOSE
//   EX->MEM pipeline register with valid/ready handshake and a 1-entry skid buffer.
//   Captures the ALU result and zero flag, store data, destination register and
//   MEM/WB control bits from the execution stage, then presents them to the memory stage.
//   Also exports a forwarding tap from its output register for the hazard/forwarding unit,
//   plus a saturating count of back-pressure cycles.
// PARAMETERS
//   B      32  datapath width (ALU result, store data)
//   RA      5  register-address width
//   CNT_W  16  stall-counter width
// PORTS
//   clk              in   1     clock, rising edge
//   reset_n          in   1     asynchronous, active-low reset
//   flush            in   1     synchronous squash of all held/incoming entries
//   in_valid         in   1     EX presents a valid entry
//   in_ready         out  1     stage can accept an entry this cycle
//   in_alu_result    in   B     ALU result
//   in_zero          in   1     ALU zero flag
//   in_store_data    in   B     rt value for stores
//   in_rd            in   RA    destination register
//   in_ctrl          in   4     {reg_write, mem_to_reg, mem_read, mem_write}
//   out_valid        out  1     entry presented to MEM
//   out_ready        in   1     MEM accepts the entry
//   out_alu_result   out  B     \
//   out_zero         out  1      | registered copies of the in_* fields
//   out_store_data   out  B      |
//   out_rd           out  RA     |
//   out_ctrl         out  4     /
//   fwd_en           out  1     out_valid & out_ctrl[3] & (out_rd != 0)
//   fwd_rd           out  RA    = out_rd
//   fwd_data         out  B     = out_alu_result
//   stall_cnt        out  CNT_W cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//   Reset (reset_n low, async): every out_*, fwd_*, stall_cnt = 0; state EMPTY; skid cleared.
//     in_ready = 0 while reset_n is low.
//   Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   in_ready = (state != SKID), combinational from registered state only; never from in_valid.
//   Latency: an entry accepted at edge N is visible on out_* after edge N.
//     Throughput is 1/cycle when out_ready is held high.
//   States and transitions, evaluated at each rising edge:
//     EMPTY : in_fire                    -> out<=in, FULL
//             otherwise                  -> EMPTY
//     FULL  : out_fire & in_fire         -> out<=in, FULL
//             out_fire & !in_fire        -> EMPTY
//             !out_fire & in_fire        -> skid<=in, SKID
//             otherwise                  -> hold, FULL
//     SKID  : out_fire                   -> out<=skid, FULL (in_ready was 0)
//             otherwise                  -> hold, SKID
//   out_valid = (state != EMPTY). out_* fields hold their value while !out_fire.
//   flush: dominates all other inputs; at the edge -> EMPTY, skid dropped,
//     same-cycle in_fire discarded. out_valid = 0 from the next cycle.
//     Data fields may keep stale values but fwd_en = 0.
//   stall_cnt: +1 each edge with out_valid & !out_ready & !flush.
//     Sticks at 2^CNT_W-1. Cleared only by reset.
//   No arithmetic on the datapath: fields pass bit-exact. RA/B widths are not extended.
//   Reset asserted mid-transfer: the entry is lost. No partial state survives.
// TESTING
//   1. Stream 4 entries (alu_result 0x10,0x20,0x30,0x40), out_ready=1
//        -> out_* show each value one cycle later; in_ready stays 1; stall_cnt=0.
//   2. Send A=0x11; hold out_ready=0; send B=0x22
//        -> state SKID, in_ready=0, out=0x11.
//      Raise out_ready
//        -> out=0x22 next cycle, then out_valid=0.
//   3. Entry rd=0, reg_write=1 -> fwd_en=0.
//      Entry rd=5, reg_write=1, result 0xDEADBEEF -> fwd_en=1, fwd_rd=5, fwd_data=0xDEADBEEF.
//   4. SKID state with in_valid=1 and flush=1
//        -> next cycle out_valid=0, in_ready=1, fwd_en=0; neither entry ever emerges.
//   5. Hold out_valid=1, out_ready=0 for 70000 cycles with CNT_W=16
//        -> stall_cnt = 0xFFFF, no wrap.
//   6. Drop reset_n mid-stream, asynchronously between edges
//        -> out_valid, fwd_en, stall_cnt = 0 and in_ready = 0 immediately.
//      Release reset_n -> in_ready = 1.

Source files
------------

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register with a valid/ready handshake and a one-entry skid buffer.
// It also exports a forwarding tap from the output register and a saturating count
// of back-pressure cycles.
module ex_mem_stage_reg #(
  parameter int B     = 32,
  parameter int RA    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [B-1:0]     in_alu_result,
  input  logic             in_zero,
  input  logic [B-1:0]     in_store_data,
  input  logic [RA-1:0]    in_rd,
  input  logic [3:0]       in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [B-1:0]     out_alu_result,
  output logic             out_zero,
  output logic [B-1:0]     out_store_data,
  output logic [RA-1:0]    out_rd,
  output logic [3:0]       out_ctrl,
  output logic             fwd_en,
  output logic [RA-1:0]    fwd_rd,
  output logic [B-1:0]     fwd_data,
  output logic [CNT_W-1:0] stall_cnt
);

  // Each entry is carried as one flat vector so that the output and skid registers share a layout.
  localparam int EW = B + 1 + B + RA + 4;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;

  state_t           r_state, w_nstate;
  logic [EW-1:0]    w_in_entry, r_out, r_skid;
  logic             w_in_fire, w_out_fire;
  logic             w_ld_out_in, w_ld_out_skid, w_ld_skid;
  logic [CNT_W-1:0] r_stall;

  assign w_in_entry = {in_alu_result, in_zero, in_store_data, in_rd, in_ctrl};

  // in_ready depends only on the registered state and on reset, never on in_valid.
  assign in_ready   = reset_n & (r_state != S_SKID);
  assign out_valid  = (r_state != S_EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  assign {out_alu_result, out_zero, out_store_data, out_rd, out_ctrl} = r_out;

  // After a flush the state is EMPTY, so out_valid gates off any stale output fields.
  assign fwd_en    = out_valid & out_ctrl[3] & (out_rd != '0);
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_alu_result;
  assign stall_cnt = r_stall;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_EMPTY;
    else          r_state <= w_nstate;
  end

  // Next state and register load selects. Flush overrides every other input.
  always_comb begin
    w_nstate      = r_state;
    w_ld_out_in   = 1'b0;
    w_ld_out_skid = 1'b0;
    w_ld_skid     = 1'b0;
    if (flush) begin
      w_nstate = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_ld_out_in = 1'b1;
            w_nstate    = S_FULL;
          end
        end
        S_FULL: begin
          if (w_out_fire && w_in_fire) begin
            w_ld_out_in = 1'b1;
          end else if (w_out_fire) begin
            w_nstate = S_EMPTY;
          end else if (w_in_fire) begin
            w_ld_skid = 1'b1;
            w_nstate  = S_SKID;
          end
        end
        S_SKID: begin
          if (w_out_fire) begin
            w_ld_out_skid = 1'b1;
            w_nstate      = S_FULL;
          end
        end
        default: w_nstate = S_EMPTY;
      endcase
    end
  end

  // Output register. It holds its value unless a new entry is loaded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           r_out <= '0;
    else if (w_ld_out_in)   r_out <= w_in_entry;
    else if (w_ld_out_skid) r_out <= r_skid;
  end

  // Skid register. It catches the entry accepted while MEM is back-pressuring.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_skid <= '0;
    else if (w_ld_skid) r_skid <= w_in_entry;
  end

  // Back-pressure counter. It saturates at all-ones and is cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_stall <= '0;
    else if (out_valid && !out_ready && !flush && (r_stall != {CNT_W{1'b1}}))
      r_stall <= r_stall + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for ex_mem_stage_reg: directed vectors plus a queue-based model checked every cycle.
module tb_ex_mem_stage_reg;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, in_zero, out_valid, out_ready;
  logic [31:0] in_alu_result, in_store_data, out_alu_result, out_store_data, fwd_data;
  logic [4:0]  in_rd, out_rd, fwd_rd;
  logic [3:0]  in_ctrl, out_ctrl;
  logic        out_zero, fwd_en;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  ex_mem_stage_reg #(.B(32), .RA(5), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_zero(in_zero), .in_store_data(in_store_data),
    .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_zero(out_zero), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_ctrl(out_ctrl),
    .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [31:0] alu;
    logic        z;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
  } ent_t;

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of at most two accepted entries, and MEM sees its head.
  ent_t q[$];
  int   mcnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      mcnt = 0;
    end else begin
      automatic bit   acc  = in_valid && (q.size() < 2);
      automatic bit   deq  = (q.size() > 0) && out_ready;
      automatic ent_t e;
      e.alu  = in_alu_result;
      e.z    = in_zero;
      e.sd   = in_store_data;
      e.rd   = in_rd;
      e.ctrl = in_ctrl;
      if (flush) begin
        q.delete();
      end else begin
        if ((q.size() > 0) && !out_ready && mcnt < 65535) mcnt++;
        if (deq) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
  end

  // Compare the DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, reset_n && (q.size() < 2)});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("stall_cnt", {16'd0, stall_cnt}, mcnt);
    if (q.size() > 0) begin
      chk("out_alu_result", out_alu_result, q[0].alu);
      chk("out_store_data", out_store_data, q[0].sd);
      chk("out_fields", {22'd0, out_zero, out_rd, out_ctrl}, {22'd0, q[0].z, q[0].rd, q[0].ctrl});
      chk("fwd_en", {31'd0, fwd_en}, {31'd0, q[0].ctrl[3] && (q[0].rd != 0)});
      chk("fwd_tap", fwd_data, q[0].alu);
    end else begin
      chk("fwd_en_empty", {31'd0, fwd_en}, 32'd0);
    end
  end

  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                       input logic [3:0] ctrl);
    in_valid      = v;
    in_alu_result = alu;
    in_store_data = ~alu;
    in_zero       = (alu == 32'd0);
    in_rd         = rd;
    in_ctrl       = ctrl;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'd0, 5'd0, 4'd0);
    #1;
    // Reset values.
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst_alu", out_alu_result, 32'd0);
    chk("rst_fwd_en", {31'd0, fwd_en}, 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1. Stream four entries with out_ready high.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i * 16), 5'(i), 4'b1000);
      cyc(1);
      chk("stream_alu", out_alu_result, 32'(i * 16));
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 32'd0, 5'd0, 4'd0);
    cyc(1);
    chk("stream_drained", {31'd0, out_valid}, 32'd0);
    chk("stream_stall", {16'd0, stall_cnt}, 32'd0);

    // 2. Skid path: A is held at the output while B lands in the skid buffer.
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd1, 4'b0010);
    cyc(1);
    chk("skid_A_out", out_alu_result, 32'h11);
    drive(1'b1, 32'h22, 5'd2, 4'b0001);
    cyc(1);
    chk("skid_in_ready", {31'd0, in_ready}, 32'd0);
    chk("skid_A_hold", out_alu_result, 32'h11);
    drive(1'b0, 32'd0, 5'd0, 4'd0);
    out_ready = 1'b1;
    cyc(1);
    chk("skid_B_out", out_alu_result, 32'h22);
    chk("skid_stall", {16'd0, stall_cnt}, 32'd1);
    cyc(1);
    chk("skid_drained", {31'd0, out_valid}, 32'd0);

    // 3. Forwarding tap.
    drive(1'b1, 32'h55, 5'd0, 4'b1000);
    cyc(1);
    chk("fwd_rd0", {31'd0, fwd_en}, 32'd0);
    drive(1'b1, 32'hDEADBEEF, 5'd5, 4'b1000);
    cyc(1);
    chk("fwd_en5", {31'd0, fwd_en}, 32'd1);
    chk("fwd_rd5", {27'd0, fwd_rd}, 32'd5);
    chk("fwd_data5", fwd_data, 32'hDEADBEEF);
    drive(1'b0, 32'd0, 5'd0, 4'd0);
    cyc(1);

    // 4. Flush while in SKID with a third entry offered.
    out_ready = 1'b0;
    drive(1'b1, 32'hC0, 5'd3, 4'b1000);
    cyc(1);
    drive(1'b1, 32'hD0, 5'd4, 4'b1000);
    cyc(1);
    chk("flush_pre_skid", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'hE0, 5'd6, 4'b1000);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 4'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_fwd_en", {31'd0, fwd_en}, 32'd0);
    out_ready = 1'b1;
    cyc(3);
    chk("flush_nothing_emerges", {31'd0, out_valid}, 32'd0);

    // 5. Saturating stall counter.
    out_ready = 1'b0;
    drive(1'b1, 32'h77, 5'd7, 4'b1000);
    cyc(1);
    drive(1'b0, 32'd0, 5'd0, 4'd0);
    cyc(70000);
    chk("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    cyc(2);

    // 6. Asynchronous reset dropped between edges, mid-stream.
    drive(1'b1, 32'h99, 5'd9, 4'b1000);
    cyc(1);
    drive(1'b1, 32'hAA, 5'd10, 4'b1000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_fwd_en", {31'd0, fwd_en}, 32'd0);
    chk("arst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 32'd0, 5'd0, 4'd0);
    cyc(2);
    #2;
    reset_n = 1'b1;
    #1;
    chk("arst_release_in_ready", {31'd0, in_ready}, 32'd1);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
